mem_ctrl: RTL and testbench

Byte-serial memory controller between the 8-bit unified RAM port and the two CPU clients: the instruction fetch stage and the MEM stage. Fetch issues one byte address per cycle and reassembles instructions itself. MEM issues whole-access requests (byte/half/word load or store), which this block sequences into little-endian byte transfers. MEM has priority: while it owns the bus, the block raises a stall request so ctrl freezes fetch, and fetch replays its in-flight bytes.

---
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: groups the fetch, MEM-stage and RAM-side signals of mem_ctrl.
//   slave  : the controller's view (takes requests and ram_din, drives the bus and results)
//   master : the surrounding CPU/RAM view (drives requests and ram_din)
// Clock and reset are plain ports on the modules, not part of this interface.
interface mem_ctrl_if;
    // fetch client
    logic        if_request;
    logic [31:0] if_addr;
    logic [7:0]  mem_ctrl_data;
    logic [1:0]  if_or_mem_o;
    // MEM client
    logic [1:0]  mem_request;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic        mem_sign;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stallreq_o;
    // RAM port
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport slave (
        input  if_request, if_addr, mem_request, mem_addr, mem_width, mem_sign,
               mem_wdata, ram_din,
        output mem_ctrl_data, if_or_mem_o, mem_rdata_o, mem_done_o, stallreq_o,
               ram_a, ram_wr, ram_dout
    );

    modport master (
        output if_request, if_addr, mem_request, mem_addr, mem_width, mem_sign,
               mem_wdata, ram_din,
        input  mem_ctrl_data, if_or_mem_o, mem_rdata_o, mem_done_o, stallreq_o,
               ram_a, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller sharing one 8-bit synchronous RAM port between
// instruction fetch (one byte address per cycle) and the MEM stage (byte/half/word
// loads and stores, sequenced little-endian). MEM has priority and raises stallreq_o.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_ctrl_if.slave: fetch request/data, MEM request/result, RAM port
module mem_ctrl (
    input  logic          clk,
    input  logic          rst,
    mem_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, LOAD, LAST, STORE, DONE} state_t;

    state_t           state, state_d;
    logic [1:0]       cnt, cnt_d;        // byte index k
    logic [31:0]      addr_q;
    logic [1:0]       width_q;
    logic             sign_q;
    logic [2:0][7:0]  wdata_hi;          // store bytes 1..3; byte 0 goes out in IDLE
    logic [2:0][7:0]  rbuf;              // load bytes 0..2; last byte comes straight from ram_din
    logic [31:0]      rdata_q;
    logic [31:0]      ext;
    logic [1:0]       last_in, last_q;   // N-1 for incoming / captured width
    logic             req_ld, req_st, mem_own;

    assign req_ld  = (bus.mem_request == 2'b01);
    assign req_st  = (bus.mem_request == 2'b10);
    assign mem_own = (state != IDLE) || req_ld || req_st;

    always_comb begin
        case (bus.mem_width)
            2'b00:   last_in = 2'd0;
            2'b01:   last_in = 2'd1;
            default: last_in = 2'd3;
        endcase
        case (width_q)
            2'b00:   last_q = 2'd0;
            2'b01:   last_q = 2'd1;
            default: last_q = 2'd3;
        endcase
    end

    // Final load byte is taken directly from ram_din in LAST.
    always_comb begin
        case (width_q)
            2'b00:   ext = {{24{sign_q & bus.ram_din[7]}}, bus.ram_din};
            2'b01:   ext = {{16{sign_q & bus.ram_din[7]}}, bus.ram_din, rbuf[0]};
            default: ext = {bus.ram_din, rbuf[2], rbuf[1], rbuf[0]};
        endcase
    end

    // next state
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                cnt_d = 2'd1;
                if (req_ld)      state_d = (last_in == 2'd0) ? LAST : LOAD;
                else if (req_st) state_d = (last_in == 2'd0) ? DONE : STORE;
                else             cnt_d   = 2'd0;
            end
            LOAD: begin
                if (cnt == last_q) state_d = LAST;
                else               cnt_d   = cnt + 2'd1;
            end
            LAST:  state_d = DONE;
            STORE: begin
                if (cnt == last_q) state_d = DONE;
                else               cnt_d   = cnt + 2'd1;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            addr_q   <= '0;
            width_q  <= 2'b00;
            sign_q   <= 1'b0;
            wdata_hi <= '0;
            rbuf     <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && (req_ld || req_st)) begin
                addr_q   <= bus.mem_addr;
                width_q  <= bus.mem_width;
                sign_q   <= bus.mem_sign;
                wdata_hi <= bus.mem_wdata[31:8];
            end
            if (state == LOAD) rbuf[cnt - 2'd1] <= bus.ram_din;
            if (state == LAST) rdata_q <= ext;
        end
    end

    // Bus steering. Gated by rst so the bus goes quiet the moment reset asserts,
    // even with requests still present on the inputs.
    always_comb begin
        bus.ram_a       = '0;
        bus.ram_wr      = 1'b0;
        bus.ram_dout    = 8'h00;
        bus.if_or_mem_o = 2'b00;
        bus.stallreq_o  = 1'b0;
        if (rst) begin
            if (mem_own) begin
                bus.if_or_mem_o = 2'b10;
                bus.stallreq_o  = (state != DONE);
                case (state)
                    IDLE: begin
                        bus.ram_a = bus.mem_addr;
                        if (req_st) begin
                            bus.ram_wr   = 1'b1;
                            bus.ram_dout = bus.mem_wdata[7:0];
                        end
                    end
                    LOAD: bus.ram_a = addr_q + {30'd0, cnt};
                    STORE: begin
                        bus.ram_a    = addr_q + {30'd0, cnt};
                        bus.ram_wr   = 1'b1;
                        bus.ram_dout = wdata_hi[cnt - 2'd1];
                    end
                    default: bus.ram_a = addr_q;
                endcase
            end else if (bus.if_request) begin
                bus.if_or_mem_o = 2'b01;
                bus.ram_a       = bus.if_addr;
            end
        end
    end

    assign bus.mem_ctrl_data = bus.ram_din;
    assign bus.mem_rdata_o   = rdata_q;
    assign bus.mem_done_o    = (state == DONE);
endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();
    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // synchronous RAM: byte for ram_a in cycle n appears on ram_din in cycle n+1
    logic [7:0]  ram [0:4095];
    logic [7:0]  rd_q;
    logic        pre_we = 1'b0;
    logic [11:0] pre_a  = '0;
    logic [7:0]  pre_d  = '0;
    always @(posedge clk) begin
        if (pre_we)          ram[pre_a] <= pre_d;
        else if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
        rd_q <= ram[bus.ram_a[11:0]];
    end
    assign bus.ram_din = rd_q;

    int tests = 0;
    int fails = 0;

    logic [31:0] log_a     [0:15];
    logic        log_wr    [0:15];
    logic [7:0]  log_dout  [0:15];
    logic        log_stall [0:15];
    logic [1:0]  log_own   [0:15];
    int          done_cyc;

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Drive one MEM access starting now (cycle 0); log bus per cycle until done.
    task automatic run_mem(input logic [1:0] req, input logic [31:0] a, input logic [1:0] w,
                           input logic s, input logic [31:0] wd);
        bus.mem_request = req; bus.mem_addr = a; bus.mem_width = w;
        bus.mem_sign = s; bus.mem_wdata = wd;
        done_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            log_a[c] = bus.ram_a; log_wr[c] = bus.ram_wr; log_dout[c] = bus.ram_dout;
            log_stall[c] = bus.stallreq_o; log_own[c] = bus.if_or_mem_o;
            @(posedge clk); #1;
            if (log_stall[c] === 1'b0 && bus.mem_done_o !== 1'b1 && done_cyc < 0 && c > 0 && dut.state == 0) begin
            end
            if (done_cyc < 0 && log_own[c] === 2'b10 && log_stall[c] === 1'b0) begin
                done_cyc = c;
                break;
            end
        end
        bus.mem_request = 2'b00;
        tests++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL mem_timeout: no done within 16 cycles, req=%b addr=%h", req, a);
        end
    endtask

    task automatic test_reset;
        bus.if_request = 1'b1; bus.if_addr = 32'h10;
        bus.mem_request = 2'b01; bus.mem_addr = 32'h20; bus.mem_width = 2'b10;
        bus.mem_sign = 1'b0; bus.mem_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.if_or_mem_o !== 2'b00) begin fails++; $display("FAIL rst_owner: got %b want 00", bus.if_or_mem_o); end
        tests++; if (bus.stallreq_o !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", bus.stallreq_o); end
        tests++; if (bus.ram_wr !== 1'b0) begin fails++; $display("FAIL rst_wr: got %b want 0", bus.ram_wr); end
        tests++; if (bus.mem_done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", bus.mem_done_o); end
        tests++; if (bus.mem_rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", bus.mem_rdata_o); end
        bus.if_request = 1'b0; bus.mem_request = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch;
        logic [7:0] exp [0:3];
        exp[0] = 8'h13; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h93;
        for (int i = 0; i < 4; i++) poke(12'(i), exp[i]);
        for (int i = 0; i < 4; i++) begin
            bus.if_request = 1'b1; bus.if_addr = 32'(i);
            @(negedge clk);
            tests++; if (bus.if_or_mem_o !== 2'b01 || bus.stallreq_o !== 1'b0 || bus.ram_a !== 32'(i)) begin
                fails++; $display("FAIL fetch_bus[%0d]: own=%b stall=%b a=%h want 01/0/%h", i, bus.if_or_mem_o, bus.stallreq_o, bus.ram_a, i);
            end
            if (i > 0) begin
                tests++; if (bus.mem_ctrl_data !== exp[i-1]) begin
                    fails++; $display("FAIL fetch_data[%0d]: got %h want %h", i-1, bus.mem_ctrl_data, exp[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        bus.if_request = 1'b0;
        @(negedge clk);
        tests++; if (bus.mem_ctrl_data !== 8'h93) begin fails++; $display("FAIL fetch_data[3]: got %h want 93", bus.mem_ctrl_data); end
        tests++; if (bus.if_or_mem_o !== 2'b00 || bus.ram_a !== 32'h0) begin
            fails++; $display("FAIL fetch_idle: own=%b a=%h want 00/0", bus.if_or_mem_o, bus.ram_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word_load;
        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        run_mem(2'b01, 32'h100, 2'b10, 1'b0, 32'h0);
        tests++; if (done_cyc !== 5) begin fails++; $display("FAIL wload_latency: got %0d want 5", done_cyc); end
        for (int c = 0; c < 4; c++) begin
            tests++; if (log_a[c] !== 32'h100 + 32'(c)) begin fails++; $display("FAIL wload_addr[%0d]: got %h want %h", c, log_a[c], 32'h100 + 32'(c)); end
        end
        for (int c = 0; c < 5; c++) begin
            tests++; if (log_stall[c] !== 1'b1) begin fails++; $display("FAIL wload_stall[%0d]: got %b want 1", c, log_stall[c]); end
        end
        tests++; if (bus.mem_rdata_o !== 32'h12345678) begin fails++; $display("FAIL wload_data: got %h want 12345678", bus.mem_rdata_o); end
    endtask

    task automatic test_sign;
        poke(12'h300, 8'h80);
        run_mem(2'b01, 32'h300, 2'b00, 1'b1, 32'h0);
        tests++; if (done_cyc !== 2) begin fails++; $display("FAIL bload_latency: got %0d want 2", done_cyc); end
        tests++; if (bus.mem_rdata_o !== 32'hFFFFFF80) begin fails++; $display("FAIL bload_signed: got %h want ffffff80", bus.mem_rdata_o); end
        run_mem(2'b01, 32'h300, 2'b00, 1'b0, 32'h0);
        tests++; if (bus.mem_rdata_o !== 32'h00000080) begin fails++; $display("FAIL bload_unsigned: got %h want 00000080", bus.mem_rdata_o); end
    endtask

    task automatic test_store;
        run_mem(2'b10, 32'h201, 2'b01, 1'b0, 32'h1234BEEF);
        tests++; if (done_cyc !== 2) begin fails++; $display("FAIL hstore_latency: got %0d want 2", done_cyc); end
        tests++; if (log_wr[0] !== 1'b1 || log_a[0] !== 32'h201 || log_dout[0] !== 8'hEF) begin
            fails++; $display("FAIL hstore_b0: wr=%b a=%h d=%h want 1/201/ef", log_wr[0], log_a[0], log_dout[0]);
        end
        tests++; if (log_wr[1] !== 1'b1 || log_a[1] !== 32'h202 || log_dout[1] !== 8'hBE) begin
            fails++; $display("FAIL hstore_b1: wr=%b a=%h d=%h want 1/202/be", log_wr[1], log_a[1], log_dout[1]);
        end
        tests++; if (log_wr[2] !== 1'b0) begin fails++; $display("FAIL hstore_done_wr: got %b want 0", log_wr[2]); end
        tests++; if (bus.mem_rdata_o !== 32'h00000080) begin fails++; $display("FAIL hstore_rdata_hold: got %h want 00000080", bus.mem_rdata_o); end
        run_mem(2'b01, 32'h201, 2'b01, 1'b0, 32'h0);
        tests++; if (done_cyc !== 3) begin fails++; $display("FAIL hload_latency: got %0d want 3", done_cyc); end
        tests++; if (bus.mem_rdata_o !== 32'h0000BEEF) begin fails++; $display("FAIL hload_readback: got %h want 0000beef", bus.mem_rdata_o); end
    endtask

    task automatic test_priority;
        bus.if_request = 1'b1; bus.if_addr = 32'h55;
        run_mem(2'b01, 32'h100, 2'b10, 1'b0, 32'h0);
        tests++; if (log_own[0] !== 2'b10 || log_a[0] !== 32'h100 || log_stall[0] !== 1'b1) begin
            fails++; $display("FAIL prio_cycle0: own=%b a=%h stall=%b want 10/100/1", log_own[0], log_a[0], log_stall[0]);
        end
        tests++; if (bus.mem_rdata_o !== 32'h12345678) begin fails++; $display("FAIL prio_data: got %h want 12345678", bus.mem_rdata_o); end
        @(negedge clk);
        tests++; if (bus.if_or_mem_o !== 2'b01 || bus.ram_a !== 32'h55 || bus.stallreq_o !== 1'b0) begin
            fails++; $display("FAIL prio_regain: own=%b a=%h stall=%b want 01/55/0", bus.if_or_mem_o, bus.ram_a, bus.stallreq_o);
        end
        @(posedge clk); #1;
        bus.if_request = 1'b0;
    endtask

    task automatic test_reset_mid_store;
        for (int i = 0; i < 4; i++) poke(12'h400 + 12'(i), 8'h11);
        bus.mem_request = 2'b10; bus.mem_addr = 32'h400; bus.mem_width = 2'b10;
        bus.mem_sign = 1'b0; bus.mem_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (bus.ram_wr !== 1'b1) begin fails++; $display("FAIL rstmid_wr_before: got %b want 1", bus.ram_wr); end
        rst = 1'b0; bus.mem_request = 2'b00;
        #1;
        tests++; if (bus.ram_wr !== 1'b0 || bus.stallreq_o !== 1'b0 || bus.if_or_mem_o !== 2'b00) begin
            fails++; $display("FAIL rstmid_immediate: wr=%b stall=%b own=%b want 0/0/00", bus.ram_wr, bus.stallreq_o, bus.if_or_mem_o);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (ram[12'h400] !== 8'hDD || ram[12'h401] !== 8'hCC || ram[12'h402] !== 8'h11 || ram[12'h403] !== 8'h11) begin
            fails++; $display("FAIL rstmid_ram: got %h %h %h %h want dd cc 11 11", ram[12'h400], ram[12'h401], ram[12'h402], ram[12'h403]);
        end
        tests++; if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h0 || bus.stallreq_o !== 1'b0 || bus.if_or_mem_o !== 2'b00
                     || bus.mem_done_o !== 1'b0 || bus.mem_rdata_o !== 32'h0 || bus.ram_dout !== 8'h00) begin
            fails++; $display("FAIL rstmid_after: wr=%b a=%h stall=%b own=%b done=%b rdata=%h dout=%h want all 0",
                              bus.ram_wr, bus.ram_a, bus.stallreq_o, bus.if_or_mem_o, bus.mem_done_o, bus.mem_rdata_o, bus.ram_dout);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_word_load;
        test_sign;
        test_store;
        test_priority;
        test_reset_mid_store;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
